dmem_arbiter: RTL
=================

# dmem_arbiter

Single-port data memory arbiter sharing the processor's data memory between the core load/store path and a host port (bench/loader for operand preload and result readback). Sits between the core datapath and the data memory. Grants at most one access per cycle, stalls the core when it loses, and returns registered read data with a one-cycle valid pulse to the winning requester.

## Interface
- AW, 8, memory address width
- DW, 8, data width
- STARVE_MAX, 4, consecutive denied host cycles before host is promoted over core (range 1..15)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- core_req  in  1  core access request, level, held until granted
- core_we  in  1  1 = store, 0 = load
- core_addr  in  AW  core address
- core_wdata  in  DW  core store data
- core_gnt  out  1  combinational grant, access performed this cycle
- core_stall  out  1  core_req & ~core_gnt; freezes core program counter
- core_rvalid  out  1  one-cycle pulse, core_rdata valid
- core_rdata  out  DW  registered load data
- host_req / host_we / host_addr / host_wdata  in  1/1/AW/DW  host request, same rules as core
- host_gnt  out  1  host grant
- host_rvalid  out  1  one-cycle pulse
- host_rdata  out  DW  registered load data
- mem_wr_en  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_dat_in  out  DW  memory write data
- mem_dat_out  in  DW  memory read data, combinational from mem_addr
- wait_cnt_o  out  4  current host starvation count (debug)

## Operation
- Owner FSM, registered: IDLE, CORE, HOST = owner of the access in the previous cycle; drives rvalid routing.
- Arbitration each cycle: neither req → no grant, next IDLE; only one req → that requester granted; both → core granted, unless wait_cnt == STARVE_MAX, then host granted.
- Transitions: owner_next = CORE if core_gnt, HOST if host_gnt, else IDLE.
- Grants mutually exclusive; never both high.
- Memory mux: granted requester's addr/wdata drive mem_addr/mem_dat_in; mem_wr_en = granted & we. No grant: mem_wr_en = 0, mem_addr = core_addr, mem_dat_in = core_wdata.
- Store: completes in the grant cycle; no rvalid.
- Load: mem_dat_out captured into the winner's rdata register at the grant edge; that winner's rvalid high for exactly the next cycle. rdata holds until the next load by the same requester.
- wait_cnt: increments (saturating at STARVE_MAX) each cycle host_req=1 and host_gnt=0; clears on host_gnt or host_req=0.
- Requester changing addr/we while req high and ungranted: latest values used; no latching before grant.

## Timing
- Reset values: core_gnt/host_gnt 0 (during reset grants forced low), core_stall = core_req, rvalid 0, rdata 0, mem_wr_en 0, wait_cnt 0, FSM IDLE.
- Grant latency: 0 cycles (combinational) when uncontended; core worst case 1 cycle stall per STARVE_MAX+1 cycles under continuous contention; host worst case STARVE_MAX stall cycles.
- Load latency: rvalid 1 cycle after grant; back-to-back loads by one requester give rvalid every cycle.
- Reset asserted mid-operation: pending rvalid suppressed the following cycle, no write occurs in the reset cycle.
- Simultaneous load by core and store by host with host promoted: host write occurs, core stalls, core retries next cycle and reads the new data.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined: starvation promotion as above.
- Undefined: strict core priority; host granted only when core_req = 0; wait_cnt logic removed, wait_cnt_o tied 0.

## Test plan
- Reset: hold reset 2 cycles with both reqs high → no grants, mem_wr_en 0, rdata 0, wait_cnt_o 0.
- Host store 0x5A to addr 0x10, then core load 0x10 → core_gnt same cycle, core_rvalid next cycle, core_rdata = 0x5A.
- Both req continuously, STARVE_MAX=4 → grants core,core,core,core,host repeating; core_stall high exactly every 5th cycle.
- Back-to-back host loads addrs 0x00..0x03 holding 1,2,3,4 → host_rvalid high 4 consecutive cycles, data 1,2,3,4.
- Core load granted, reset asserted next cycle → core_rvalid stays 0, owner IDLE.
- Macro undefined, both req for 20 cycles → host_gnt never asserts, core_stall 0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundle of every bus signal between the two requesters (core load/store
// path, host loader port), the arbiter and the single-port data memory.
//
// Handshake rules, shared by both requesters:
//   *_req is a level request. The requester holds it, and may change
//   *_we/_addr/_wdata, until *_gnt is seen high in the same cycle. The
//   access is performed in the grant cycle. For a load, *_rvalid pulses for
//   exactly the following cycle with *_rdata holding the loaded word.
//   *_rdata then holds until the next load by the same requester.
//
// Modports:
//   slave  - arbiter side: takes requests and memory read data, drives
//            grants, read data and the memory address/write strobe.
//   master - requester and memory side (cores, loader, memory model).
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // core load/store path
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  // host (loader / readback) port
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  // single-port data memory
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dat_in;
  logic [DW-1:0] mem_dat_out;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_wr_en, mem_addr, mem_dat_in,
    input  mem_dat_out
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_wr_en, mem_addr, mem_dat_in,
    output mem_dat_out
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the core load/store path and
// a host port. At most one access is granted per cycle. Grants are
// combinational, so an uncontended request is served in the cycle it is
// raised. The core is stalled in any cycle it requests and loses. Load
// data is registered per requester and announced by a one-cycle rvalid.
//
// Build option:
//   DMEM_ARB_STARVE_GUARD_EN  defined   -> host is promoted over the core
//                                          after STARVE_MAX consecutive
//                                          denied cycles.
//                             undefined -> strict core priority; the
//                                          starvation counter is absent and
//                                          wait_cnt_o reads 0.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous, active-high
//   bus        dmem_arbiter_if.slave (requesters + memory)
//   wait_cnt_o current host starvation count (debug)
//   owner_o    owner FSM state: 0 IDLE, 1 CORE, 2 HOST (debug)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus,
  output logic [3:0]           wait_cnt_o,
  output logic [1:0]           owner_o
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..15");
  end

  // Owner of the access performed in the previous cycle. It decides which
  // requester sees the rvalid pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    HOST = 2'd2
  } owner_t;

  owner_t        owner;
  logic          last_load;     // previous cycle's granted access was a load
  logic [DW-1:0] core_rdata_q;
  logic [DW-1:0] host_rdata_q;
  logic [3:0]    wait_cnt;
  logic          core_gnt;
  logic          host_gnt;
  logic          host_promoted;

  // -------------------------------------------------------------------------
  // Host starvation counter
  // -------------------------------------------------------------------------
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Counts consecutive cycles the host asked and was refused. Saturates at
  // the limit so the promotion condition is a plain equality compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (!bus.host_req || host_gnt) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != STARVE_LIM) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign host_promoted = (wait_cnt == STARVE_LIM);
`else
  assign wait_cnt      = 4'd0;
  assign host_promoted = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Arbitration: core wins ties unless the host has been starved long
  // enough. Reset forces both grants low so nothing reaches the memory.
  // -------------------------------------------------------------------------
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      if (bus.core_req && bus.host_req) begin
        if (host_promoted) begin
          host_gnt = 1'b1;
        end else begin
          core_gnt = 1'b1;
        end
      end else if (bus.core_req) begin
        core_gnt = 1'b1;
      end else if (bus.host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Memory mux. With no grant the core's address is presented so the
  // memory port still sees a defined, quiet address; the write strobe is
  // only ever raised for the granted requester.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_addr   = bus.core_addr;
    bus.mem_dat_in = bus.core_wdata;
    bus.mem_wr_en  = 1'b0;
    if (host_gnt) begin
      bus.mem_addr   = bus.host_addr;
      bus.mem_dat_in = bus.host_wdata;
      bus.mem_wr_en  = bus.host_we;
    end else if (core_gnt) begin
      bus.mem_wr_en  = bus.core_we;
    end
  end

  // -------------------------------------------------------------------------
  // Owner FSM plus the per-requester read data registers. Load data is
  // captured at the grant edge; the owner then routes the rvalid pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= IDLE;
      last_load    <= 1'b0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      if (core_gnt) begin
        owner     <= CORE;
        last_load <= !bus.core_we;
      end else if (host_gnt) begin
        owner     <= HOST;
        last_load <= !bus.host_we;
      end else begin
        owner     <= IDLE;
        last_load <= 1'b0;
      end

      if (core_gnt && !bus.core_we) begin
        core_rdata_q <= bus.mem_dat_out;
      end
      if (host_gnt && !bus.host_we) begin
        host_rdata_q <= bus.mem_dat_out;
      end
    end
  end

  // Exactly one requester may own the memory in a cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(core_gnt && host_gnt));
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. rvalid is masked by reset so a load granted just before reset
  // never reports its data.
  // -------------------------------------------------------------------------
  assign bus.core_gnt    = core_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.core_stall  = bus.core_req && !core_gnt;
  assign bus.core_rvalid = (owner == CORE) && last_load && !reset;
  assign bus.host_rvalid = (owner == HOST) && last_load && !reset;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.host_rdata  = host_rdata_q;
  assign wait_cnt_o      = wait_cnt;
  assign owner_o         = owner;

endmodule
